// File: rtl/sram_scanout_reader.sv
// sram_scanout_reader: Avalon-MM read initiator on SRAM port s2 that scans an
// H_RES x V_RES frame from a base address and streams the pixels in raster
// order on an Avalon-ST source with backpressure.
// Optional build macro: SCANOUT_CONTINUOUS_EN -- frames repeat back-to-back
// from the latched base until reset.
module sram_scanout_reader #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 8,
    parameter int H_RES      = 320,
    parameter int V_RES      = 240,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              frame_done,
    output logic [ADDR_W-1:0] sram_address,
    output logic              sram_chipselect,
    output logic              sram_clken,
    output logic              sram_write,
    output logic [DATA_W-1:0] sram_writedata,
    input  logic [DATA_W-1:0] sram_readdata,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_sop,
    output logic              st_eop
);

    localparam int X_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int Y_W = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int P_W = $clog2(FIFO_DEPTH);
    localparam int E_W = DATA_W + 2;   // {sop, eop, data}

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] base, offset;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic              inflight, pend_sop, pend_eop;
    logic [E_W-1:0]    mem [FIFO_DEPTH];
    logic [P_W-1:0]    wr_ptr, rd_ptr;
    logic [P_W:0]      count;
    logic              issue, x_last, y_last, pix_first, pix_last, push, pop;
    logic [E_W-1:0]    head;

    assign x_last    = (x == X_W'(H_RES - 1));
    assign y_last    = (y == Y_W'(V_RES - 1));
    assign pix_last  = x_last & y_last;
    assign pix_first = (x == '0) && (y == '0);

    // Credit rule: entries held plus the read in flight never exceed the
    // FIFO, so a returning read always has a slot.
    assign issue = (state == FETCH) &&
                   ((count + {{P_W{1'b0}}, inflight}) < (P_W + 1)'(FIFO_DEPTH));

    assign push     = inflight;
    assign st_valid = (count != '0);
    assign pop      = st_valid & st_ready;
    assign head     = mem[rd_ptr];

    assign st_data    = st_valid ? head[DATA_W-1:0] : '0;
    assign st_sop     = st_valid & head[DATA_W+1];
    assign st_eop     = st_valid & head[DATA_W];
    assign frame_done = pop & head[DATA_W];
    assign busy       = (state != IDLE);

    assign sram_address    = base + offset;
    assign sram_chipselect = issue;
    assign sram_clken      = issue;
    assign sram_write      = 1'b0;
    assign sram_writedata  = '0;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic; start is only honoured from IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = FETCH;
            FETCH: if (issue && pix_last) begin
`ifdef SCANOUT_CONTINUOUS_EN
                       state_nx = FETCH;
`else
                       state_nx = DRAIN;
`endif
                   end
            DRAIN: if (frame_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Base latch and scan position; offset tracks y*H_RES+x by increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base   <= '0;
            offset <= '0;
            x      <= '0;
            y      <= '0;
        end else if (state == IDLE && start) begin
            base   <= base_addr;
            offset <= '0;
            x      <= '0;
            y      <= '0;
        end else if (issue) begin
            if (pix_last) begin
                offset <= '0;
                x      <= '0;
                y      <= '0;
            end else begin
                offset <= offset + 1'b1;
                if (x_last) begin
                    x <= '0;
                    y <= y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
        end
    end

    // One-cycle read latency: remember frame markers of the read in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= 1'b0;
            pend_sop <= 1'b0;
            pend_eop <= 1'b0;
        end else begin
            inflight <= issue;
            pend_sop <= issue & pix_first;
            pend_eop <= issue & pix_last;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while the slot is empty
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {pend_sop, pend_eop, sram_readdata};
    end

endmodule
